register_read_sequencer: RTL and testbench
==========================================

Name: register_read_sequencer

Overview:
- Read-side counterpart to the datapath's write-enabled holding registers.
- Holds a 16-entry register bank for the multi-cycle ARM datapath and fetches up to three source operands (Rn, Rm, Rs) through a single read port, one per cycle.
- Handles R15 as PC+8 and forwards a same-cycle write to the register being read.
- Signals completion with a one-cycle valid pulse to the multi-cycle control FSM.

Parameters:
- W, 32, data width of registers, PC and operands
- AW, 4, register address width (16 registers; index 15 = PC)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block
- start  input  1  request operand fetch; sampled only in IDLE
- num_ops  input  2  number of operands to read: 0..3
- addr_a  input  AW  first operand register index
- addr_b  input  AW  second operand register index
- addr_c  input  AW  third operand register index
- pc_in  input  W  current instruction address; sampled with start
- write  input  1  register bank write enable
- waddr  input  AW  register bank write index
- DATA  input  W  register bank write data
- busy  output  1  high while a fetch is in progress, including the DONE cycle
- valid  output  1  one-cycle pulse: op_a..op_c are complete
- op_a  output  W  operand from addr_a
- op_b  output  W  operand from addr_b
- op_c  output  W  operand from addr_c

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; all 15 bank entries, op_a/op_b/op_c and the latched PC cleared to 0; busy=0, valid=0.
  - Any in-flight fetch is aborted with no valid pulse.
  - A write in the same cycle is dropped.
- Bank write:
  - Any state; write==1 at posedge sets bank[waddr]<=DATA.
  - waddr==15 is ignored; the PC is owned externally.
  - Bank entries hold their value otherwise.
- FSM states: IDLE, READ_A, READ_B, READ_C, DONE.
- IDLE:
  - On start==1, latch addr_a/b/c, num_ops and pc_in.
  - Next state: num_ops=0 -> DONE; otherwise -> READ_A.
  - start==0 -> stay in IDLE.
- READ_A:
  - op_a <= read(addr_a).
  - Next state: READ_B if num_ops>=2, else DONE.
- READ_B:
  - op_b <= read(addr_b).
  - Next state: READ_C if num_ops==3, else DONE.
- READ_C: op_c <= read(addr_c); next state DONE.
- DONE: valid=1 for this cycle only; next state IDLE.
- read(x), evaluated in the cycle of the read state:
  - x==15 -> latched_pc + 8, truncated mod 2^W.
  - else if write==1 and waddr==x -> DATA (forwarding).
  - else -> bank[x].
- Operands not read in a request keep their previous values (e.g. num_ops=1 leaves op_b and op_c unchanged).
- Outputs:
  - busy=1 in READ_A, READ_B, READ_C and DONE; 0 in IDLE.
  - valid and busy are registered state decodes, with no combinational path from inputs.
- Latency: start accepted at edge T -> valid high in cycle T+num_ops+1 (num_ops=0 -> valid in cycle T+1).
- Back-to-back operation:
  - start while busy is ignored and not queued.
  - start is accepted again in the first IDLE cycle after DONE.
  - Minimum request spacing is num_ops+2 cycles.
- Duplicate addresses, e.g. addr_a==addr_b, are legal; each read is independent, so a write between the two reads makes them differ.
- Addresses and pc_in changing after start have no effect on the in-flight fetch.

Test Plan:
- Reset then read: release reset; write R3=0x11, R7=0x22, R9=0x33; start num_ops=3 (a=3,b=7,c=9) -> busy high for 4 cycles, valid after 4 cycles, op_a=0x11, op_b=0x22, op_c=0x33.
- PC read: pc_in=0x100, start num_ops=2 (a=15,b=3); write R15=0xDEAD during the fetch -> op_a=0x108, op_b=0x11; a later read of R15 still returns latched PC+8, the write is ignored.
- Forwarding: during READ_B with addr_b=7, drive write=1, waddr=7, DATA=0xAA -> op_b=0xAA; next fetch of R7 returns 0xAA.
- Partial and zero ops: after the first test, start num_ops=1 (a=9) -> valid after 2 cycles, op_a=0x33, op_b/op_c keep 0x22/0x33; num_ops=0 -> valid in the cycle after start, no operand changes.
- Start while busy: assert start continuously across two requests -> the second start is taken only in the IDLE cycle after DONE; exactly one valid per accepted start.
- Mid-operation reset: reset=0 during READ_B -> next cycle state IDLE, busy=0, valid never pulses, op_a/b/c=0, R3 reads back 0.

Source files
------------

// File: rtl/register_read_sequencer_if.sv
// Operand-fetch bus between the multi-cycle control FSM and the register read sequencer.
// master: request (start, num_ops, addr_a/b/c, pc_in), bank write port (write, waddr, DATA).
// slave: status and results (busy, valid, op_a/op_b/op_c).
interface register_read_sequencer_if #(
    parameter int W  = 32,
    parameter int AW = 4
);
    logic          start;
    logic [1:0]    num_ops;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [AW-1:0] addr_c;
    logic [W-1:0]  pc_in;
    logic          write;
    logic [AW-1:0] waddr;
    logic [W-1:0]  DATA;
    logic          busy;
    logic          valid;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  op_c;

    modport master (
        output start, num_ops, addr_a, addr_b, addr_c, pc_in, write, waddr, DATA,
        input  busy, valid, op_a, op_b, op_c
    );

    modport slave (
        input  start, num_ops, addr_a, addr_b, addr_c, pc_in, write, waddr, DATA,
        output busy, valid, op_a, op_b, op_c
    );
endinterface

// File: rtl/register_read_sequencer.sv
// Register bank (R0..R14, R15 = latched PC+8) read one operand per cycle through a single port.
// Latency: start accepted at edge T -> valid pulse in cycle T+num_ops+1.
// No backpressure: start is ignored while busy and never queued.
// Ports: clk, reset (sync, active-low); bus (slave modport) carries request, write port and results.
module register_read_sequencer #(
    parameter int W  = 32,
    parameter int AW = 4
) (
    input logic                   clk,
    input logic                   reset,
    register_read_sequencer_if.slave bus
);
    localparam int            NREG   = 1 << AW;
    localparam logic [AW-1:0] PC_IDX = '1;

    typedef enum logic [2:0] {IDLE, READ_A, READ_B, READ_C, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  bank [0:NREG-2];   // no storage for the PC slot
    logic [AW-1:0] addr_a_q, addr_b_q, addr_c_q;
    logic [1:0]    num_ops_q;
    logic [W-1:0]  pc_q;
    logic [W-1:0]  op_a_q, op_b_q, op_c_q;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_dat;

    // Single read port: the address follows the read state.
    always_comb begin
        rd_addr = addr_a_q;
        case (state)
            READ_B:  rd_addr = addr_b_q;
            READ_C:  rd_addr = addr_c_q;
            default: rd_addr = addr_a_q;
        endcase
    end

    // R15 wins over forwarding: the PC is never written through the bank port.
    always_comb begin
        rd_dat = '0;
        if (rd_addr == PC_IDX)
            rd_dat = pc_q + W'(8);
        else if (bus.write && (bus.waddr == rd_addr))
            rd_dat = bus.DATA;
        else
            rd_dat = bank[rd_addr];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.num_ops == 2'd0) ? DONE : READ_A;
            READ_A:  state_nxt = (num_ops_q >= 2'd2) ? READ_B : DONE;
            READ_B:  state_nxt = (num_ops_q == 2'd3) ? READ_C : DONE;
            READ_C:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            addr_c_q  <= '0;
            num_ops_q <= '0;
            pc_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_c_q    <= '0;
            for (int i = 0; i < NREG - 1; i++)
                bank[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                addr_a_q  <= bus.addr_a;
                addr_b_q  <= bus.addr_b;
                addr_c_q  <= bus.addr_c;
                num_ops_q <= bus.num_ops;
                pc_q      <= bus.pc_in;
            end
            if (bus.write && (bus.waddr != PC_IDX))
                bank[bus.waddr] <= bus.DATA;
            case (state)
                READ_A:  op_a_q <= rd_dat;
                READ_B:  op_b_q <= rd_dat;
                READ_C:  op_c_q <= rd_dat;
                default: ;
            endcase
        end
    end

    // Pure decodes of the state register: no input-to-output path.
    assign bus.busy  = (state != IDLE);
    assign bus.valid = (state == DONE);
    assign bus.op_a  = op_a_q;
    assign bus.op_b  = op_b_q;
    assign bus.op_c  = op_c_q;
endmodule

// File: tb/tb_register_read_sequencer.sv
// Directed plus randomized bench for register_read_sequencer.
// Reference: an array of 16 register values, updated by each accepted write and
// read out at the cycle each operand is fetched (PC+8 for R15, same-cycle write visible).
module tb_register_read_sequencer;
    localparam int W  = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    register_read_sequencer_if #(.W(W), .AW(AW)) bus ();

    register_read_sequencer #(.W(W), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mbank [16];
    logic [31:0] mops [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input bit rnd);
        if (rnd) begin
            bus.write = 1'($urandom_range(0, 1));
            bus.waddr = 4'($urandom_range(0, 15));
            bus.DATA  = $urandom;
        end else begin
            bus.write = 1'b0;
            bus.waddr = '0;
            bus.DATA  = '0;
        end
    endtask

    // Model consequence of this cycle's write (only when not in reset).
    task automatic commit();
        if (reset && bus.write && bus.waddr != 4'd15)
            mbank[bus.waddr] = bus.DATA;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a, input logic [31:0] pc);
        if (a == 4'd15) return pc + 32'd8;
        if (bus.write && bus.waddr == a) return bus.DATA;
        return mbank[a];
    endfunction

    task automatic check_ops(input string tag);
        chk({tag, ".op_a"}, bus.op_a, mops[0]);
        chk({tag, ".op_b"}, bus.op_b, mops[1]);
        chk({tag, ".op_c"}, bus.op_c, mops[2]);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.write = 1'b1;
        bus.waddr = a;
        bus.DATA  = d;
        commit();
        tick();
        set_wr(0);
    endtask

    // One full request from an IDLE cycle back to the following IDLE cycle.
    // fk selects the fetch step (0..2) that sees a directed write fa<=fd; -1 for none.
    task automatic run_req(input int n, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [31:0] pc, input bit rnd,
                           input int fk, input logic [3:0] fa, input logic [31:0] fd);
        logic [3:0] la [3];
        la[0] = a; la[1] = b; la[2] = c;
        bus.start   = 1'b1;
        bus.num_ops = 2'(n);
        bus.addr_a  = a;
        bus.addr_b  = b;
        bus.addr_c  = c;
        bus.pc_in   = pc;
        set_wr(rnd);
        commit();
        tick();
        // Request inputs are don't-care once accepted.
        bus.start  = 1'b0;
        bus.addr_a = 4'($urandom_range(0, 15));
        bus.addr_b = 4'($urandom_range(0, 15));
        bus.addr_c = 4'($urandom_range(0, 15));
        bus.pc_in  = $urandom;
        for (int k = 0; k < n; k++) begin
            chk("fetch.busy", 32'(bus.busy), 32'd1);
            chk("fetch.valid", 32'(bus.valid), 32'd0);
            if (k == fk) begin
                bus.write = 1'b1;
                bus.waddr = fa;
                bus.DATA  = fd;
            end else begin
                set_wr(rnd);
            end
            mops[k] = model_read(la[k], pc);
            commit();
            tick();
        end
        chk("done.valid", 32'(bus.valid), 32'd1);
        chk("done.busy", 32'(bus.busy), 32'd1);
        check_ops("done");
        set_wr(rnd);
        commit();
        tick();
        chk("idle.valid", 32'(bus.valid), 32'd0);
        chk("idle.busy", 32'(bus.busy), 32'd0);
        set_wr(0);
    endtask

    initial begin
        foreach (mbank[i]) mbank[i] = '0;
        foreach (mops[i]) mops[i] = '0;
        bus.start = 1'b0; bus.num_ops = '0;
        bus.addr_a = '0; bus.addr_b = '0; bus.addr_c = '0; bus.pc_in = '0;
        set_wr(0);

        // Reset; a write during reset is dropped.
        tick();
        bus.write = 1'b1; bus.waddr = 4'd4; bus.DATA = 32'h5;
        commit();
        tick();
        set_wr(0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.valid", 32'(bus.valid), 32'd0);
        check_ops("rst");
        reset = 1'b1;

        // Basic three-operand read.
        wr(4'd3, 32'h11);
        wr(4'd7, 32'h22);
        wr(4'd9, 32'h33);
        run_req(3, 4'd3, 4'd7, 4'd9, 32'h0, 0, -1, 4'd0, 32'h0);
        // Partial and zero-operand requests leave other operands alone.
        run_req(1, 4'd9, 4'd1, 4'd2, 32'h0, 0, -1, 4'd0, 32'h0);
        run_req(0, 4'd3, 4'd7, 4'd9, 32'h0, 0, -1, 4'd0, 32'h0);
        // R4 was written only during reset.
        run_req(1, 4'd4, 4'd0, 4'd0, 32'h0, 0, -1, 4'd0, 32'h0);
        // PC read with an ignored R15 write during the fetch.
        run_req(2, 4'd15, 4'd3, 4'd0, 32'h100, 0, 0, 4'd15, 32'hDEAD);
        run_req(1, 4'd15, 4'd0, 4'd0, 32'h200, 0, -1, 4'd0, 32'h0);
        run_req(1, 4'd15, 4'd0, 4'd0, 32'hFFFF_FFFC, 0, -1, 4'd0, 32'h0);
        // Forwarding in READ_B, then the written value persists.
        run_req(2, 4'd3, 4'd7, 4'd0, 32'h0, 0, 1, 4'd7, 32'hAA);
        run_req(1, 4'd7, 4'd0, 4'd0, 32'h0, 0, -1, 4'd0, 32'h0);
        // Duplicate address with a write between the two reads.
        run_req(2, 4'd5, 4'd5, 4'd0, 32'h0, 0, 0, 4'd5, 32'h77);

        // start held high: one acceptance every num_ops+2 = 3 cycles.
        bus.start = 1'b1; bus.num_ops = 2'd1; bus.addr_a = 4'd9;
        tick();
        for (int i = 1; i <= 9; i++) begin
            chk("hold.valid", 32'(bus.valid), 32'((i % 3) == 2));
            chk("hold.busy", 32'(bus.busy), 32'((i % 3) != 0));
            tick();
        end
        bus.start = 1'b0;
        tick();
        tick();
        mops[0] = mbank[9];
        chk("hold.idle", 32'(bus.busy), 32'd0);
        check_ops("hold");

        // Reset during READ_B aborts the fetch.
        bus.start = 1'b1; bus.num_ops = 2'd3;
        bus.addr_a = 4'd3; bus.addr_b = 4'd7; bus.addr_c = 4'd9;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        foreach (mbank[i]) mbank[i] = '0;
        foreach (mops[i]) mops[i] = '0;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.valid", 32'(bus.valid), 32'd0);
        check_ops("abort");
        for (int i = 0; i < 4; i++) begin
            chk("abort.novalid", 32'(bus.valid), 32'd0);
            tick();
        end
        run_req(1, 4'd3, 4'd0, 4'd0, 32'h0, 0, -1, 4'd0, 32'h0);

        // Randomized requests with random background writes.
        for (int r = 0; r < 40; r++) begin
            run_req($urandom_range(0, 3), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    $urandom, 1, $urandom_range(0, 3) - 1,
                    4'($urandom_range(0, 15)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
